// File: rtl/serial_receiver.sv
// serial_receiver: oversampled 8N1 receiver with a one-deep holding register,
// a one-cycle framing-error pulse and a sticky overrun flag.
//
//   state | meaning
//   IDLE  | waiting for a synchronized 1->0 edge on the line
//   START | counting to mid start bit to reject glitches
//   DATA  | sampling 8 data bits, LSB first, one per bit time
//   STOP  | sampling the stop bit one bit time after data bit 7
module serial_receiver #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serialDataIn,
  input  logic       readAck,
  output logic [7:0] parallelDataOut,
  output logic       dataValid,
  output logic       framingError,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] samp_q, samp_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;

  logic sync1_q, sync2_q, prev_q;
  logic stop_smp, good_d, bad_d;
  logic good_q, bad_q;
  logic [7:0] data_q;
  logic valid_q, ovr_q, ferr_q;

  // Two-flop synchronizer plus one history flop for falling-edge detection;
  // all reset high so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= serialDataIn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // State, counters and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      samp_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    samp_d  = samp_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = START;
          samp_d  = '0;
        end
      end
      START: begin
        if (samp_q == HALF_M1) begin
          samp_d = '0;
          bit_d  = '0;
          // A high line at mid start bit was only a glitch.
          state_d = sync2_q ? IDLE : DATA;
        end else begin
          samp_d = samp_q + CW'(1);
        end
      end
      DATA: begin
        if (samp_q == FULL_M1) begin
          samp_d = '0;
          shift_d[bit_q] = sync2_q;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          samp_d = samp_q + CW'(1);
        end
      end
      STOP: begin
        if (samp_q == FULL_M1) begin
          samp_d  = '0;
          state_d = IDLE;
        end else begin
          samp_d = samp_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: busy and the stop-bit verdict.
  always_comb begin
    busy     = (state_q != IDLE);
    stop_smp = (state_q == STOP) && (samp_q == FULL_M1);
    good_d   = stop_smp && sync2_q;
    bad_d    = stop_smp && !sync2_q;
  end

  // Holding register; the stop verdict is registered once so the character
  // lands one edge after the stop sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      good_q  <= 1'b0;
      bad_q   <= 1'b0;
      ferr_q  <= 1'b0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      good_q <= good_d;
      bad_q  <= bad_d;
      ferr_q <= bad_q;
      if (good_q) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
        if (valid_q) ovr_q <= !readAck;
      end else if (readAck && valid_q) begin
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end
    end
  end

  assign parallelDataOut = data_q;
  assign dataValid       = valid_q;
  assign framingError    = ferr_q;
  assign overrun         = ovr_q;

endmodule

// File: tb/tb_serial_receiver.sv
// Bench for serial_receiver: table of frames with hand-derived results,
// corner-case sequences, and random traffic against an event-scheduled model.
module tb_serial_receiver;

  localparam int OS       = 16;
  localparam int DET_OFS  = 2;
  localparam int END_OFS  = DET_OFS + OS / 2 + 9 * OS;
  localparam int DONE_OFS = END_OFS + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       serialDataIn = 1'b1;
  logic       readAck = 1'b0;
  logic [7:0] parallelDataOut;
  logic       dataValid, framingError, overrun, busy;

  serial_receiver #(.OVERSAMPLE(OS)) dut (
    .clk(clk), .rst(rst), .serialDataIn(serialDataIn), .readAck(readAck),
    .parallelDataOut(parallelDataOut), .dataValid(dataValid),
    .framingError(framingError), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ferr_cnt = 0;
  bit chk_en = 1'b0;

  // Expected outputs, driven by events scheduled when stimulus is generated.
  logic [7:0] m_data = 8'h00;
  bit m_valid = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0, m_busy = 1'b0;
  logic [7:0] good_at[int];
  bit bad_at[int];
  bit bs_at[int];
  bit be_at[int];

  typedef struct {
    logic [7:0] d;
    bit         stop;
    bit         ack_before;
    bit         ack_done;
    logic [7:0] exp_data;
    bit         exp_valid;
    bit         exp_ovr;
    int         exp_ferr;
  } vec_t;
  vec_t tbl[10];

  function automatic void chk(string name, logic [7:0] act, logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, cyc, act, exp);
    end
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      m_data = 8'h00; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_busy = 1'b0;
      good_at.delete(); bad_at.delete(); bs_at.delete(); be_at.delete();
    end else begin
      m_ferr = bad_at.exists(cyc);
      if (good_at.exists(cyc)) begin
        if (m_valid && !readAck) m_ovr = 1'b1;
        else if (readAck)        m_ovr = 1'b0;
        m_data  = good_at[cyc];
        m_valid = 1'b1;
      end else if (readAck && m_valid) begin
        m_valid = 1'b0;
        m_ovr   = 1'b0;
      end
      if (bs_at.exists(cyc)) m_busy = 1'b1;
      if (be_at.exists(cyc)) m_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("parallelDataOut", parallelDataOut, m_data);
      chk("dataValid", 8'(dataValid), 8'(m_valid));
      chk("overrun", 8'(overrun), 8'(m_ovr));
      chk("framingError", 8'(framingError), 8'(m_ferr));
      chk("busy", 8'(busy), 8'(m_busy));
      if (framingError === 1'b1) ferr_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sched_frame(int k, logic [7:0] d, bit stop);
    bs_at[k + DET_OFS] = 1'b1;
    be_at[k + END_OFS] = 1'b1;
    if (stop) good_at[k + DONE_OFS] = d;
    else      bad_at[k + DONE_OFS]  = 1'b1;
  endtask

  task automatic send_frame(logic [7:0] d, bit stop, bit ack_done, int ack_pct,
                            int gap, bit chk_lat);
    int k;
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    k = cyc + 1;
    sched_frame(k, d, stop);
    for (int t = 0; t < 10 * OS; t++) begin
      serialDataIn = bits[t / OS];
      readAck = ((ack_done && t == DONE_OFS) ||
                 (int'($urandom_range(0, 99)) < ack_pct)) ? 1'b1 : 1'b0;
      step();
      if (chk_lat) begin
        if (t == DET_OFS - 1) chk("lat busy before detect", 8'(busy), 8'h00);
        if (t == DET_OFS)     chk("lat busy at detect", 8'(busy), 8'h01);
        if (t == END_OFS - 1) chk("lat busy last stop cycle", 8'(busy), 8'h01);
        if (t == END_OFS)     chk("lat busy after stop", 8'(busy), 8'h00);
        if (t == END_OFS)     chk("lat valid early", 8'(dataValid), 8'h00);
        if (t == DONE_OFS)    chk("lat valid at k+155", 8'(dataValid), 8'h01);
      end
    end
    for (int g = 0; g < gap; g++) begin
      serialDataIn = 1'b1;
      readAck = (int'($urandom_range(0, 99)) < ack_pct) ? 1'b1 : 1'b0;
      step();
    end
    serialDataIn = 1'b1;
    readAck = 1'b0;
  endtask

  task automatic glitch(int len, bit chk_busy);
    int k;
    k = cyc + 1;
    bs_at[k + DET_OFS] = 1'b1;
    be_at[k + DET_OFS + OS / 2] = 1'b1;
    for (int t = 0; t < OS / 2 + 16; t++) begin
      serialDataIn = (t < len) ? 1'b0 : 1'b1;
      step();
      if (chk_busy && t == DET_OFS + OS / 2 - 1) chk("glitch busy held", 8'(busy), 8'h01);
      if (chk_busy && t == DET_OFS + OS / 2)     chk("glitch busy dropped", 8'(busy), 8'h00);
    end
    serialDataIn = 1'b1;
  endtask

  task automatic pulse_ack();
    readAck = 1'b1;
    step();
    readAck = 1'b0;
    step();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] bits;
    int k;
    tbl[0] = '{8'hAA, 1'b1, 1'b0, 1'b0, 8'hAA, 1'b1, 1'b0, 0};
    tbl[1] = '{8'h55, 1'b0, 1'b0, 1'b0, 8'hAA, 1'b1, 1'b0, 1};
    tbl[2] = '{8'h0F, 1'b1, 1'b0, 1'b0, 8'h0F, 1'b1, 1'b1, 0};
    tbl[3] = '{8'hF0, 1'b1, 1'b0, 1'b0, 8'hF0, 1'b1, 1'b1, 0};
    tbl[4] = '{8'h12, 1'b1, 1'b1, 1'b0, 8'h12, 1'b1, 1'b0, 0};
    tbl[5] = '{8'h34, 1'b1, 1'b0, 1'b1, 8'h34, 1'b1, 1'b0, 0};
    tbl[6] = '{8'hC3, 1'b1, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0, 0};
    tbl[7] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0};
    tbl[8] = '{8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1};
    tbl[9] = '{8'h81, 1'b1, 1'b0, 1'b0, 8'h81, 1'b1, 1'b0, 0};

    step();
    chk_en = 1'b1;
    step();
    chk("reset data", parallelDataOut, 8'h00);
    chk("reset valid", 8'(dataValid), 8'h00);
    chk("reset ferr", 8'(framingError), 8'h00);
    chk("reset ovr", 8'(overrun), 8'h00);
    chk("reset busy", 8'(busy), 8'h00);
    rst = 1'b0;
    repeat (4) step();

    foreach (tbl[i]) begin
      if (tbl[i].ack_before) pulse_ack();
      ferr_cnt = 0;
      send_frame(tbl[i].d, tbl[i].stop, tbl[i].ack_done, 0,
                 tbl[i].stop ? 0 : 4, (i == 0));
      chk($sformatf("vec%0d data", i), parallelDataOut, tbl[i].exp_data);
      chk($sformatf("vec%0d valid", i), 8'(dataValid), 8'(tbl[i].exp_valid));
      chk($sformatf("vec%0d ovr", i), 8'(overrun), 8'(tbl[i].exp_ovr));
      chk($sformatf("vec%0d ferr cycles", i), 8'(ferr_cnt), 8'(tbl[i].exp_ferr));
    end

    // Back-to-back frames without acknowledgement, then one ack.
    send_frame(8'h0F, 1'b1, 1'b0, 0, 0, 1'b0);
    send_frame(8'hF0, 1'b1, 1'b0, 0, 0, 1'b0);
    chk("b2b data", parallelDataOut, 8'hF0);
    chk("b2b valid", 8'(dataValid), 8'h01);
    chk("b2b ovr", 8'(overrun), 8'h01);
    pulse_ack();
    chk("ack valid", 8'(dataValid), 8'h00);
    chk("ack ovr", 8'(overrun), 8'h00);
    pulse_ack();
    chk("ack idle no effect", 8'(dataValid), 8'h00);

    // Four-cycle low glitch on an idle line.
    glitch(4, 1'b1);
    chk("glitch valid", 8'(dataValid), 8'h00);
    chk("glitch data", parallelDataOut, 8'hF0);

    // Reset during data bit 4, then a clean frame.
    send_frame(8'h5A, 1'b1, 1'b0, 0, 2, 1'b0);
    chk("pre-rst valid", 8'(dataValid), 8'h01);
    bits = {1'b1, 8'h3C, 1'b0};
    k = cyc + 1;
    sched_frame(k, 8'h3C, 1'b1);
    for (int t = 0; t < 10 * OS; t++) begin
      rst = (t == 5 * OS + OS / 2) ? 1'b1 : 1'b0;
      serialDataIn = (t < 5 * OS + OS / 2) ? bits[t / OS] : 1'b1;
      step();
    end
    rst = 1'b0;
    chk("rst data", parallelDataOut, 8'h00);
    chk("rst valid", 8'(dataValid), 8'h00);
    chk("rst ovr", 8'(overrun), 8'h00);
    chk("rst busy", 8'(busy), 8'h00);
    repeat (10) step();
    send_frame(8'h3C, 1'b1, 1'b0, 0, 2, 1'b0);
    chk("post-rst data", parallelDataOut, 8'h3C);
    chk("post-rst valid", 8'(dataValid), 8'h01);
    chk("post-rst ovr", 8'(overrun), 8'h00);

    // Random traffic: frames, bad stops, glitches and sporadic acks.
    for (int n = 0; n < 40; n++) begin
      int r;
      bit stop;
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        glitch(int'($urandom_range(1, 6)), 1'b0);
      end else begin
        stop = (r != 1);
        send_frame(8'($urandom), stop, 1'b0, 3,
                   stop ? int'($urandom_range(0, 20)) : int'($urandom_range(4, 20)),
                   1'b0);
      end
    end

    repeat (8) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_receiver.md
SERIAL_RECEIVER -- requirements
Module: serial_receiver

Interface
REQ-001 Parameter: OVERSAMPLE, 16, clk cycles per serial bit time; SHALL be an even value >= 4.
REQ-002 Port: clk  input  1  single 16x oversampling clock; all logic SHALL be on its rising edge.
REQ-003 Port: rst  input  1  synchronous active-high reset.
REQ-004 Port: serialDataIn  input  1  asynchronous serial line; idles high.
REQ-005 Port: readAck  input  1  consumer acknowledges the held character.
REQ-006 Port: parallelDataOut  output  8  last good received character.
REQ-007 Port: dataValid  output  1  parallelDataOut holds an unacknowledged character.
REQ-008 Port: framingError  output  1  one-cycle pulse when a stop bit is sampled low.
REQ-009 Port: overrun  output  1  sticky flag: a character was overwritten before acknowledgement.
REQ-010 Port: busy  output  1  high in every state other than IDLE.

Function
REQ-011 Frame SHALL be: start bit 0, 8 data bits LSB first, stop bit 1, with each bit lasting OVERSAMPLE cycles.
REQ-012 serialDataIn SHALL pass through a 2-flop synchronizer before any use; both flops SHALL reset to 1.
REQ-013 State machine SHALL have the states IDLE, START, DATA and STOP, plus one bit counter (0-7) and one sample counter (0 to OVERSAMPLE-1).
REQ-014 IDLE: a synchronized 1->0 transition (previous 1, current 0) SHALL move to START and clear the sample counter; a line held low SHALL NOT retrigger.
REQ-015 START: sample at sample count OVERSAMPLE/2-1 (8 cycles after detection for the default); if 0, go to DATA and clear the counters; if 1, treat as a false start and return to IDLE with no output change.
REQ-016 DATA: sample every OVERSAMPLE cycles after the start sample; shift the sample into bit position bit-count; after bit 7, go to STOP.
REQ-017 STOP: sample OVERSAMPLE cycles after bit 7; then return to IDLE.
REQ-018 Stop sample = 1: on the next edge, load parallelDataOut and set dataValid.
REQ-019 Stop sample = 0: pulse framingError for one cycle; parallelDataOut, dataValid and overrun SHALL be unchanged.
REQ-020 readAck while dataValid=1: clear dataValid and overrun on the next edge.
REQ-021 readAck while dataValid=0: no effect.
REQ-022 A good character completing while dataValid=1 and readAck=0 SHALL overwrite parallelDataOut, keep dataValid=1 and set overrun.
REQ-023 A good character completing in the same cycle as readAck SHALL load the new data, keep dataValid=1 and leave overrun=0.
REQ-024 Latency: with the first clk edge sampling serialDataIn low at edge k, edge detection SHALL occur at k+2 and dataValid SHALL be high from edge k+2+OVERSAMPLE/2+9*OVERSAMPLE+1 (k+155 for the default).
REQ-025 After a framing error, the receiver SHALL re-arm only on a fresh 1->0 transition.

Reset
REQ-026 While rst=1 the state SHALL be IDLE and the counters 0, with parallelDataOut=8'h00, dataValid=0, framingError=0, overrun=0 and busy=0.
REQ-027 rst asserted mid-frame SHALL abort the frame on the next edge with no partial data visible; reception SHALL resume on the next falling edge after rst is released.

Verification
REQ-028 Send a frame carrying 8'hAA (line falls at edge k) -> dataValid rises at k+155, parallelDataOut=8'hAA, framingError never asserted, busy=0 after the stop sample.
REQ-029 Low glitch of 4 cycles on an idle line -> start check fails, return to IDLE, dataValid stays 0 and busy drops 8 cycles after detection.
REQ-030 Frame 8'h55 with the stop bit driven 0 -> single-cycle framingError pulse; dataValid and parallelDataOut unchanged from their prior values.
REQ-031 Frames 8'h0F then 8'hF0 back-to-back with no readAck -> parallelDataOut=8'hF0, dataValid=1, overrun=1; then a readAck pulse -> dataValid=0 and overrun=0.
REQ-032 readAck asserted on the exact cycle a second frame completes -> new data loaded, dataValid=1, overrun=0.
REQ-033 rst pulsed during data bit 4 -> all outputs reset and no data is loaded; the next full frame 8'h3C is received correctly.
